// File: rtl/seg_s2p_rx.sv
// Purpose: rebuild WIDTH-bit parallel frames from the 4-wire shift-chain link (s_clk/s_sout/s_clrn/s_pen).
// Latency: SYNC_STAGES clk cycles after an input edge is first sampled, the shift/latch/pulse lands.
// Backpressure: none; the link is free-running and every frame end is reported (valid or frame_err).
module seg_s2p_rx #(
    parameter int WIDTH       = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          s_clk,
    input  logic                          s_sout,
    input  logic                          s_clrn,
    input  logic                          s_pen,
    output logic [WIDTH-1:0]              p_data,
    output logic                          valid,
    output logic                          frame_err,
    output logic                          busy,
    output logic [$clog2(WIDTH+2)-1:0]    bit_cnt
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // Bit positions of the link signals inside the synchronizer bundle.
    localparam int L_CLK = 0;
    localparam int L_DAT = 1;
    localparam int L_CLR = 2;
    localparam int L_PEN = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // All four link wires share one chain so their relative timing is kept intact.
    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic [3:0]                  link_in;
    logic [3:0]                  link_s;
    logic                        clk_prev;
    logic                        pen_prev;
    logic                        clk_rise;
    logic                        pen_rise;
    logic                        clr_act;

    state_t                      state;
    state_t                      state_n;
    logic [WIDTH-1:0]            sr;
    logic [WIDTH-1:0]            sr_n;
    logic [WIDTH-1:0]            sr_shift;
    logic [WIDTH-1:0]            sr_after;
    logic [CW-1:0]               cnt_n;
    logic [CW-1:0]               cnt_shift;
    logic [CW-1:0]               cnt_after;
    logic [WIDTH-1:0]            pdata_n;
    logic                        valid_n;
    logic                        ferr_n;
    logic                        end_frame;

    assign link_in = {s_pen, s_clrn, s_sout, s_clk};
    assign link_s  = sync_q[SYNC_STAGES-1];

    // Synchronizer chains plus one history flop for each edge-detected signal.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q   <= '0;
            clk_prev <= 1'b0;
            pen_prev <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], link_in};
            clk_prev <= link_s[L_CLK];
            pen_prev <= link_s[L_PEN];
        end
    end

    // Rising-edge strobes and the level-sensitive clear, all in the clk domain.
    always_comb begin
        clk_rise = link_s[L_CLK] & ~clk_prev;
        pen_rise = link_s[L_PEN] & ~pen_prev;
        clr_act  = ~link_s[L_CLR];
    end

    // Next-state logic: the shift is applied first, so a latch edge in the same
    // cycle as a clock edge checks the count including that bit.
    always_comb begin
        state_n   = state;
        sr_n      = sr;
        cnt_n     = bit_cnt;
        pdata_n   = p_data;
        valid_n   = 1'b0;
        ferr_n    = 1'b0;
        end_frame = 1'b0;

        sr_shift  = {sr[WIDTH-2:0], link_s[L_DAT]};
        cnt_shift = (bit_cnt == CNT_SAT) ? CNT_SAT : bit_cnt + CNT_ONE;
        sr_after  = clk_rise ? sr_shift  : sr;
        cnt_after = clk_rise ? cnt_shift : bit_cnt;

        if (clr_act) begin
            // Clear dominates every edge; the last good frame stays visible.
            state_n = IDLE;
            sr_n    = '0;
            cnt_n   = '0;
        end else begin
            sr_n  = sr_after;
            cnt_n = cnt_after;
            case (state)
                IDLE: begin
                    // A latch edge with no bits received is not a frame.
                    if (clk_rise) begin
                        state_n   = SHIFT;
                        end_frame = pen_rise;
                    end
                end
                SHIFT: begin
                    end_frame = pen_rise;
                end
            endcase

            if (end_frame) begin
                state_n = IDLE;
                cnt_n   = '0;
                if (cnt_after == CNT_FULL) begin
                    valid_n = 1'b1;
                    pdata_n = sr_after;
                end else begin
                    ferr_n  = 1'b1;
                end
            end
        end
    end

    // State, shift register and all outputs are registered; busy tracks the next state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            sr        <= '0;
            bit_cnt   <= '0;
            p_data    <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            sr        <= sr_n;
            bit_cnt   <= cnt_n;
            p_data    <= pdata_n;
            valid     <= valid_n;
            frame_err <= ferr_n;
            busy      <= (state_n == SHIFT);
        end
    end

endmodule

// File: tb/tb_seg_s2p_rx.sv
// Bench for seg_s2p_rx: drives the link on falling clk edges, checks pulses against a scoreboard.
// Latency: frame-end pulse expected on the 3rd rising clk edge after the s_pen rise.
// Backpressure: none; every pulse must match the oldest queued expectation.
module tb_seg_s2p_rx;

    logic        clk;
    logic        rstn;
    logic        s_clk;
    logic        s_sout;
    logic        s_clrn;
    logic        s_pen;
    logic [63:0] p_data;
    logic        valid;
    logic        frame_err;
    logic        busy;
    logic [6:0]  bit_cnt;

    typedef struct {
        logic        is_err;
        logic [63:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] model_pdata;
    int          checks;
    int          errors;

    seg_s2p_rx dut (
        .clk       (clk),
        .rstn      (rstn),
        .s_clk     (s_clk),
        .s_sout    (s_sout),
        .s_clrn    (s_clrn),
        .s_pen     (s_pen),
        .p_data    (p_data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy),
        .bit_cnt   (bit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard consumer: each pulse pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (valid || frame_err) begin
            checks++;
            if (valid && frame_err) begin
                errors++;
                $display("FAIL pulse_exclusive valid=%0b frame_err=%0b required one-hot", valid, frame_err);
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse valid=%0b frame_err=%0b p_data=%h required no pulse",
                         valid, frame_err, p_data);
            end else begin
                e = sb.pop_front();
                if (frame_err !== e.is_err || p_data !== e.data) begin
                    errors++;
                    $display("FAIL scoreboard frame_err=%0b p_data=%h required frame_err=%0b p_data=%h",
                             frame_err, p_data, e.is_err, e.data);
                end
            end
        end
    end

    task automatic push_valid(input logic [63:0] d);
        exp_t e;
        e.is_err = 1'b0;
        e.data   = d;
        sb.push_back(e);
        model_pdata = d;
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1;
        e.data   = model_pdata;
        sb.push_back(e);
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk) s_sout = b;
        @(negedge clk) s_clk = 1'b1;
        repeat (4) @(negedge clk);
        s_clk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_bits(input logic [127:0] d, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(d[i]);
    endtask

    task automatic pulse_pen();
        @(negedge clk) s_pen = 1'b1;
        repeat (6) @(negedge clk);
        s_pen = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL %s_missing_pulse pending=%0d required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (p_data !== 64'h0 || valid !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_data p_data=%h valid=%0b frame_err=%0b required 0", p_data, valid, frame_err);
        end
        checks++;
        if (busy !== 1'b0 || bit_cnt !== 7'd0) begin
            errors++;
            $display("FAIL reset_state busy=%0b bit_cnt=%0d required 0", busy, bit_cnt);
        end
        rstn = 1'b1;
        model_pdata = 64'h0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        push_valid(64'h0123_4567_89AB_CDEF);
        send_bits({64'h0, 64'h0123_4567_89AB_CDEF}, 64);
        checks++;
        if (bit_cnt !== 7'd64 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_count bit_cnt=%0d busy=%0b required 64 1", bit_cnt, busy);
        end
        @(negedge clk) s_pen = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_early valid=%0b busy=%0b required 0 1", valid, busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (valid !== 1'b1 || busy !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency valid=%0b busy=%0b frame_err=%0b required 1 0 0", valid, busy, frame_err);
        end
        checks++;
        if (p_data !== 64'h0123_4567_89AB_CDEF || bit_cnt !== 7'd0) begin
            errors++;
            $display("FAIL basic_data p_data=%h bit_cnt=%0d required 0123456789abcdef 0", p_data, bit_cnt);
        end
        repeat (6) @(negedge clk);
        s_pen = 1'b0;
        repeat (6) @(negedge clk);
        check_drained("basic");
    endtask

    task automatic test_short();
        push_err();
        send_bits({64'h0, 64'hA5A5_5A5A_0F0F_F0F0}, 63);
        checks++;
        if (bit_cnt !== 7'd63) begin
            errors++;
            $display("FAIL short_count bit_cnt=%0d required 63", bit_cnt);
        end
        pulse_pen();
        checks++;
        if (bit_cnt !== 7'd0 || p_data !== model_pdata) begin
            errors++;
            $display("FAIL short_after bit_cnt=%0d p_data=%h required 0 %h", bit_cnt, p_data, model_pdata);
        end
        check_drained("short");
    endtask

    task automatic test_overflow();
        push_err();
        send_bits({58'h0, 70'h2A_DEAD_BEEF_1234_5678}, 70);
        checks++;
        if (bit_cnt !== 7'd65) begin
            errors++;
            $display("FAIL overflow_count bit_cnt=%0d required 65", bit_cnt);
        end
        pulse_pen();
        checks++;
        if (p_data !== model_pdata || busy !== 1'b0) begin
            errors++;
            $display("FAIL overflow_after p_data=%h busy=%0b required %h 0", p_data, busy, model_pdata);
        end
        check_drained("overflow");
    endtask

    task automatic test_clear();
        send_bits({64'h0, 64'h000F_FFFF}, 20);
        checks++;
        if (bit_cnt !== 7'd20) begin
            errors++;
            $display("FAIL clear_pre bit_cnt=%0d required 20", bit_cnt);
        end
        @(negedge clk) s_clrn = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (bit_cnt !== 7'd0 || busy !== 1'b0 || p_data !== model_pdata) begin
            errors++;
            $display("FAIL clear_hold bit_cnt=%0d busy=%0b p_data=%h required 0 0 %h",
                     bit_cnt, busy, p_data, model_pdata);
        end
        s_clrn = 1'b1;
        repeat (4) @(negedge clk);
        push_valid(64'hFFFF_0000_FFFF_0000);
        send_bits({64'h0, 64'hFFFF_0000_FFFF_0000}, 64);
        pulse_pen();
        checks++;
        if (p_data !== 64'hFFFF_0000_FFFF_0000) begin
            errors++;
            $display("FAIL clear_frame p_data=%h required ffff0000ffff0000", p_data);
        end
        check_drained("clear");
    endtask

    task automatic test_reset_mid();
        send_bits({64'h0, 64'h1234_5678}, 30);
        @(negedge clk) rstn = 1'b0;
        #1;
        checks++;
        if (p_data !== 64'h0 || bit_cnt !== 7'd0 || busy !== 1'b0 || valid !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs p_data=%h bit_cnt=%0d busy=%0b valid=%0b frame_err=%0b required 0",
                     p_data, bit_cnt, busy, valid, frame_err);
        end
        model_pdata = 64'h0;
        repeat (4) @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        pulse_pen();
        checks++;
        if (bit_cnt !== 7'd0 || busy !== 1'b0 || p_data !== 64'h0) begin
            errors++;
            $display("FAIL reset_mid_idle bit_cnt=%0d busy=%0b p_data=%h required 0 0 0", bit_cnt, busy, p_data);
        end
        check_drained("reset_mid");
    endtask

    task automatic test_back_to_back();
        push_valid(64'hFFFF_FFFF_FFFF_FFFF);
        send_bits({64'h0, 64'hFFFF_FFFF_FFFF_FFFF}, 64);
        pulse_pen();
        checks++;
        if (p_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++;
            $display("FAIL b2b_first p_data=%h required ffffffffffffffff", p_data);
        end
        push_valid(64'h0);
        send_bits(128'h0, 63);
        // Last bit's clock edge and the latch edge arrive together.
        @(negedge clk) s_sout = 1'b0;
        @(negedge clk);
        s_clk = 1'b1;
        s_pen = 1'b1;
        repeat (4) @(negedge clk);
        s_clk = 1'b0;
        repeat (4) @(negedge clk);
        s_pen = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (p_data !== 64'h0 || bit_cnt !== 7'd0) begin
            errors++;
            $display("FAIL b2b_second p_data=%h bit_cnt=%0d required 0 0", p_data, bit_cnt);
        end
        check_drained("b2b");
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        model_pdata = 64'h0;
        rstn        = 1'b0;
        s_clk       = 1'b0;
        s_sout      = 1'b0;
        s_clrn      = 1'b1;
        s_pen       = 1'b0;
        test_reset();
        test_basic();
        test_short();
        test_overflow();
        test_clear();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
